// File: rtl/wb_bridge_pkg.sv
// ---------------------------------------------------------------------------
// wb_bridge_pkg
// Shared types and helpers for the pipelined-to-classic Wishbone bridge.
//   wb_rsp_e  : kind of completion returned to the pipelined master
//   cnt_width : width of an occupancy counter that must hold 0..depth
// The request record itself (we/adr/dat/sel) depends on the bridge's width
// parameters, so it is declared inside the bridge and handed to the queue
// as a type parameter.
// ---------------------------------------------------------------------------
package wb_bridge_pkg;

    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_ACK  = 2'd1,
        RSP_ERR  = 2'd2
    } wb_rsp_e;

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/wb_bridge_req_fifo.sv
// ---------------------------------------------------------------------------
// wb_req_fifo
// In-order request queue for the Wishbone bridge.
//   clk_i, rst_i : clock, synchronous active-high reset
//   flush_i      : discard every entry on the next edge (wins over push)
//   push_i       : write data_i at the tail (ignored when full)
//   data_i       : request record to enqueue
//   pop_i        : drop the head entry (ignored when empty)
//   head_o       : current head entry (stale when empty)
//   full_o       : DEPTH entries held
//   empty_o      : no entries held
// DEPTH must be a power of two so the pointers wrap on their own.
// ---------------------------------------------------------------------------
module wb_req_fifo
    import wb_bridge_pkg::*;
#(
    parameter type         T     = logic,
    parameter int unsigned DEPTH = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic flush_i,
    input  logic push_i,
    input  T     data_i,
    input  logic pop_i,
    output T     head_o,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = cnt_width(DEPTH);

    T              mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (do_push && !do_pop)      cnt_d = cnt_q + CW'(1);
            else if (!do_push && do_pop) cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/wb_pipe2std_bridge.sv
// ---------------------------------------------------------------------------
// wb_pipe2std_bridge
// Wishbone B4 bridge: pipelined master in, classic slave out. Up to DEPTH
// requests are queued and replayed in order; each returns one m_ack_o or
// m_err_o. A hung slave is cut off after TIMEOUT wait cycles (0 = never).
//   clk_i, rst_i            : clock, synchronous active-high reset
//   m_cyc_i/m_stb_i/m_we_i  : master cycle, strobe, write enable
//   m_adr_i/m_dat_i/m_sel_i : master address, write data, byte selects
//   m_stall_o               : queue full or in reset
//   m_ack_o/m_err_o         : one-cycle completion pulses
//   m_dat_o                 : read data, meaningful with m_ack_o
//   s_cyc_o/s_stb_o/s_we_o  : classic slave cycle, strobe, write enable
//   s_adr_o/s_dat_o/s_sel_o : slave address, write data, byte selects
//   s_ack_i/s_err_i/s_dat_i : slave termination and read data
// ---------------------------------------------------------------------------
module wb_pipe2std_bridge
    import wb_bridge_pkg::*;
#(
    parameter int unsigned ADR_WIDTH = 16,
    parameter int unsigned DAT_WIDTH = 16,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   m_cyc_i,
    input  logic                   m_stb_i,
    input  logic                   m_we_i,
    input  logic [ADR_WIDTH-1:0]   m_adr_i,
    input  logic [DAT_WIDTH-1:0]   m_dat_i,
    input  logic [DAT_WIDTH/8-1:0] m_sel_i,
    output logic                   m_stall_o,
    output logic                   m_ack_o,
    output logic                   m_err_o,
    output logic [DAT_WIDTH-1:0]   m_dat_o,
    output logic                   s_cyc_o,
    output logic                   s_stb_o,
    output logic                   s_we_o,
    output logic [ADR_WIDTH-1:0]   s_adr_o,
    output logic [DAT_WIDTH-1:0]   s_dat_o,
    output logic [DAT_WIDTH/8-1:0] s_sel_o,
    input  logic                   s_ack_i,
    input  logic                   s_err_i,
    input  logic [DAT_WIDTH-1:0]   s_dat_i
);

    localparam int unsigned SEL_WIDTH = DAT_WIDTH / 8;
    localparam int unsigned TW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef struct packed {
        logic                 we;
        logic [ADR_WIDTH-1:0] adr;
        logic [DAT_WIDTH-1:0] dat;
        logic [SEL_WIDTH-1:0] sel;
    } wb_req_t;

    wb_req_t              push_req, head;
    logic                 full, empty;
    logic                 push, pop, stb, term, timeout;
    logic [TW-1:0]        wait_q, wait_d;
    logic                 gap_q, gap_d;
    wb_rsp_e              rsp_q, rsp_d;
    logic [DAT_WIDTH-1:0] rdat_q, rdat_d;

    assign push_req = '{we: m_we_i, adr: m_adr_i, dat: m_dat_i, sel: m_sel_i};
    assign push     = m_cyc_i & m_stb_i & ~m_stall_o;

    // gap_q is the single idle cycle after a timeout pop; the queued error
    // response rides on it.
    assign stb     = ~empty & m_cyc_i & ~gap_q & ~rst_i;
    assign term    = stb & (s_ack_i | s_err_i);
    assign timeout = (TIMEOUT != 0) && stb && !term && (wait_q == TW'(TIMEOUT));
    assign pop     = term | timeout;

    wb_req_fifo #(
        .T     (wb_req_t),
        .DEPTH (DEPTH)
    ) u_req_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (~m_cyc_i),
        .push_i  (push),
        .data_i  (push_req),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        wait_d = wait_q;
        gap_d  = timeout;
        rsp_d  = RSP_NONE;
        rdat_d = rdat_q;

        if (!stb || term || timeout) wait_d = '0;
        else if (TIMEOUT != 0)       wait_d = wait_q + TW'(1);

        // Nothing is reported for a cycle the master has already abandoned.
        if (m_cyc_i) begin
            if (gap_q) begin
                rsp_d = RSP_ERR;
            end else if (term) begin
                if (s_err_i) begin
                    rsp_d = RSP_ERR;
                end else begin
                    rsp_d  = RSP_ACK;
                    rdat_d = s_dat_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_q <= '0;
            gap_q  <= 1'b0;
            rsp_q  <= RSP_NONE;
            rdat_q <= '0;
        end else begin
            wait_q <= wait_d;
            gap_q  <= gap_d;
            rsp_q  <= rsp_d;
            rdat_q <= rdat_d;
        end
    end

    assign m_stall_o = full | rst_i;
    // Pulses are gated by the live m_cyc_i so an abort cancels the pulse
    // that would otherwise land in the abort cycle itself.
    assign m_ack_o   = (rsp_q == RSP_ACK) & m_cyc_i & ~rst_i;
    assign m_err_o   = (rsp_q == RSP_ERR) & m_cyc_i & ~rst_i;
    assign m_dat_o   = rst_i ? '0 : rdat_q;

    assign s_cyc_o = stb;
    assign s_stb_o = stb;
    assign s_we_o  = stb & head.we;
    assign s_adr_o = stb ? head.adr : '0;
    assign s_dat_o = stb ? head.dat : '0;
    assign s_sel_o = stb ? head.sel : '0;

endmodule

// File: tb/tb_wb_pipe2std_bridge.sv
module tb_wb_pipe2std_bridge;

    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int SW    = DW / 8;
    localparam int DEPTH = 4;
    localparam int TMO   = 8;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          m_cyc_i = 1'b0, m_stb_i = 1'b0, m_we_i = 1'b0;
    logic [AW-1:0] m_adr_i = '0;
    logic [DW-1:0] m_dat_i = '0;
    logic [SW-1:0] m_sel_i = '0;
    logic          m_stall_o, m_ack_o, m_err_o;
    logic [DW-1:0] m_dat_o;
    logic          s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0] s_adr_o;
    logic [DW-1:0] s_dat_o;
    logic [SW-1:0] s_sel_o;
    logic          s_ack_i = 1'b0, s_err_i = 1'b0;
    logic [DW-1:0] s_dat_i = '0;

    always #5 clk_i = ~clk_i;

    wb_pipe2std_bridge #(
        .ADR_WIDTH (AW),
        .DAT_WIDTH (DW),
        .DEPTH     (DEPTH),
        .TIMEOUT   (TMO)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .m_cyc_i   (m_cyc_i),
        .m_stb_i   (m_stb_i),
        .m_we_i    (m_we_i),
        .m_adr_i   (m_adr_i),
        .m_dat_i   (m_dat_i),
        .m_sel_i   (m_sel_i),
        .m_stall_o (m_stall_o),
        .m_ack_o   (m_ack_o),
        .m_err_o   (m_err_o),
        .m_dat_o   (m_dat_o),
        .s_cyc_o   (s_cyc_o),
        .s_stb_o   (s_stb_o),
        .s_we_o    (s_we_o),
        .s_adr_o   (s_adr_o),
        .s_dat_o   (s_dat_o),
        .s_sel_o   (s_sel_o),
        .s_ack_i   (s_ack_i),
        .s_err_i   (s_err_i),
        .s_dat_i   (s_dat_i)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        logic [SW-1:0] sel;
    } req_t;

    typedef struct {
        logic          err;
        logic          we;
        logic [DW-1:0] rdat;
    } rsp_t;

    req_t req_list[$];   // master requests not yet accepted
    req_t iss_q[$];      // accepted, not yet presented to the slave
    rsp_t rsp_q[$];      // expected completions in acceptance order

    int n_chk = 0, n_pass = 0;
    int n_ack = 0, n_err = 0;

    // scenario knobs
    int slave_wait = 0, hang_adr = -1, err_adr = -1, idle_pct = 0;
    bit err_both = 1'b1;
    bit want_cyc = 1'b0, rst_req = 1'b1;

    // reference model state
    int            cyc_n = 0, q_cnt = 0, wcnt = 0;
    int            to_pop_cyc = -10, gap_cyc = -10, to_due = -10;
    bit            term_prev = 1'b0, in_xfer = 1'b0, stb_pend = 1'b0, stall_seen = 1'b0;
    logic [AW-1:0] cur_adr = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc_n);
    endtask

    task automatic add_req(input int we, input int adr, input int dat, input int sel);
        req_t r;
        r.we  = (we != 0);
        r.adr = AW'(adr);
        r.dat = DW'(dat);
        r.sel = SW'(sel);
        req_list.push_back(r);
    endtask

    task automatic step();
        req_t r;
        rsp_t e;
        bit   aborted, acc, term, exp_pulse;
        @(posedge clk_i);
        #1;
        cyc_n++;
        s_ack_i = 1'b0;
        s_err_i = 1'b0;
        s_dat_i = '0;
        rst_i   = rst_req;
        m_cyc_i = want_cyc;
        if (!want_cyc) stb_pend = 1'b0;
        else if (!stb_pend && req_list.size() > 0 && $urandom_range(99) >= idle_pct) stb_pend = 1'b1;
        m_stb_i = stb_pend;
        if (stb_pend) begin
            r = req_list[0];
            m_we_i  = r.we;
            m_adr_i = r.adr;
            m_dat_i = r.dat;
            m_sel_i = r.sel;
        end else begin
            m_we_i  = 1'b0;
            m_adr_i = '0;
            m_dat_i = '0;
            m_sel_i = '0;
        end
        #1;
        aborted = !want_cyc || rst_req;

        chk("m_stall", 64'(m_stall_o), 64'(rst_req || q_cnt == DEPTH));
        if (!rst_req && m_stall_o) stall_seen = 1'b1;
        chk("s_cyc_stb", 64'({s_cyc_o, s_stb_o}),
            64'({2{!aborted && q_cnt > 0 && cyc_n != gap_cyc}}));

        if (m_ack_o) n_ack++;
        if (m_err_o) n_err++;
        exp_pulse = !aborted && (term_prev || cyc_n == to_due);
        chk("m_pulse", 64'(m_ack_o | m_err_o), 64'(exp_pulse));
        if (exp_pulse && (m_ack_o | m_err_o)) begin
            if (rsp_q.size() == 0) begin
                chk("rsp_extra", 64'(1), 64'(0));
            end else begin
                e = rsp_q.pop_front();
                chk("rsp_kind", 64'({m_ack_o, m_err_o}), 64'({!e.err, e.err}));
                if (!e.err && !e.we) chk("m_dat_o", 64'(m_dat_o), 64'(e.rdat));
            end
        end
        if (rst_req)
            chk("rst_outs", 64'({m_ack_o, m_err_o, m_dat_o, s_we_o, s_adr_o, s_dat_o, s_sel_o}), 64'(0));

        acc  = m_cyc_i && m_stb_i && !m_stall_o;
        term = 1'b0;
        if (aborted) begin
            iss_q.delete();
            rsp_q.delete();
            q_cnt      = 0;
            to_due     = -10;
            to_pop_cyc = -10;
            gap_cyc    = -10;
            in_xfer    = 1'b0;
            acc        = 1'b0;
        end else if (s_stb_o) begin
            if (!in_xfer) begin
                if (iss_q.size() == 0) begin
                    chk("stale_xfer", 64'(1), 64'(0));
                end else begin
                    r = iss_q.pop_front();
                    chk("s_req", 64'({s_we_o, s_adr_o, s_dat_o, s_sel_o}),
                        64'({r.we, r.adr, r.dat, r.sel}));
                end
                in_xfer = 1'b1;
                wcnt    = 0;
                cur_adr = s_adr_o;
                if (int'(s_adr_o) == hang_adr) begin
                    to_pop_cyc = cyc_n + TMO;
                    gap_cyc    = to_pop_cyc + 1;
                    to_due     = to_pop_cyc + 2;
                end
            end else begin
                chk("s_adr_hold", 64'(s_adr_o), 64'(cur_adr));
            end
            if (int'(cur_adr) != hang_adr && wcnt == slave_wait) begin
                if (int'(cur_adr) == err_adr) begin
                    s_err_i = 1'b1;
                    s_ack_i = err_both;
                end else begin
                    s_ack_i = 1'b1;
                end
                s_dat_i = cur_adr + 16'd100;
                term    = 1'b1;
                in_xfer = 1'b0;
            end else begin
                wcnt++;
            end
        end else begin
            in_xfer = 1'b0;
        end

        term_prev = term;
        if (acc) begin
            r = req_list.pop_front();
            iss_q.push_back(r);
            e.err  = (int'(r.adr) == hang_adr) || (int'(r.adr) == err_adr);
            e.we   = r.we;
            e.rdat = r.adr + 16'd100;
            rsp_q.push_back(e);
            stb_pend = 1'b0;
        end
        q_cnt = q_cnt + (acc ? 1 : 0) - (term ? 1 : 0) - ((cyc_n == to_pop_cyc) ? 1 : 0);
    endtask

    task automatic run_to_done(input int max_cyc);
        int k = 0;
        while ((req_list.size() > 0 || rsp_q.size() > 0 || q_cnt > 0) && k < max_cyc) begin
            step();
            k++;
        end
        if (req_list.size() > 0 || rsp_q.size() > 0 || q_cnt > 0)
            chk("done_timeout", 64'(0), 64'(1));
    endtask

    task automatic end_cycle();
        want_cyc = 1'b0;
        step();
        want_cyc = 1'b1;
    endtask

    initial begin
        int a0, e0, k, n;

        // reset
        rst_req = 1'b1;
        step();
        step();
        rst_req = 1'b0;
        step();
        want_cyc = 1'b1;

        // back-to-back writes, zero-wait slave
        slave_wait = 0; idle_pct = 0; stall_seen = 1'b0; a0 = n_ack;
        for (int i = 1; i <= 10; i++) add_req(1, i, 100 + i, 3);
        run_to_done(200);
        chk("t1_nostall", 64'(stall_seen), 64'(0));
        chk("t1_acks", 64'(n_ack - a0), 64'(10));
        end_cycle();

        // wait-state reads
        slave_wait = 2; stall_seen = 1'b0; a0 = n_ack;
        for (int i = 1; i <= 10; i++) add_req(0, i, $urandom, 3);
        run_to_done(300);
        chk("t2_stalled", 64'(stall_seen), 64'(1));
        chk("t2_acks", 64'(n_ack - a0), 64'(10));
        end_cycle();

        // timeout on adr 5
        slave_wait = 1; hang_adr = 5; a0 = n_ack; e0 = n_err;
        for (int i = 1; i <= 10; i++) add_req(0, i, 0, 3);
        run_to_done(400);
        chk("t3_errs", 64'(n_err - e0), 64'(1));
        chk("t3_acks", 64'(n_ack - a0), 64'(9));
        hang_adr = -1;
        end_cycle();

        // s_err together with s_ack on adr 3
        slave_wait = 0; err_adr = 3; err_both = 1'b1; a0 = n_ack; e0 = n_err;
        for (int i = 1; i <= 6; i++) add_req(0, i, 0, 1);
        run_to_done(200);
        chk("t4_errs", 64'(n_err - e0), 64'(1));
        chk("t4_acks", 64'(n_ack - a0), 64'(5));
        err_adr = -1;
        end_cycle();

        // abort with three queued
        slave_wait = 4;
        for (int i = 20; i <= 22; i++) add_req(1, i, i, 3);
        k = 0;
        while (q_cnt < 3 && k < 20) begin step(); k++; end
        chk("t5_queued", 64'(q_cnt), 64'(3));
        want_cyc = 1'b0;
        step();
        step();
        want_cyc = 1'b1;
        slave_wait = 0; a0 = n_ack;
        for (int i = 30; i <= 32; i++) add_req(0, i, 0, 3);
        run_to_done(100);
        chk("t5_new_acks", 64'(n_ack - a0), 64'(3));
        end_cycle();

        // reset during a write burst
        slave_wait = 1;
        for (int i = 1; i <= 6; i++) add_req(1, 40 + i, 200 + i, 3);
        repeat (4) step();
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        req_list.delete();
        stb_pend = 1'b0;
        repeat (5) step();
        end_cycle();

        // randomized bursts
        for (int b = 0; b < 14; b++) begin
            slave_wait = $urandom_range(3);
            idle_pct   = $urandom_range(60);
            err_adr    = $urandom_range(31);
            err_both   = ($urandom_range(1) != 0);
            hang_adr   = ($urandom_range(3) == 0) ? int'($urandom_range(31)) : -1;
            n = $urandom_range(12, 1);
            for (int i = 0; i < n; i++)
                add_req($urandom_range(1), $urandom_range(31), $urandom, $urandom_range(3));
            if ($urandom_range(3) == 0) begin
                k = $urandom_range(15, 3);
                repeat (k) step();
                req_list.delete();
                end_cycle();
            end else begin
                run_to_done(600);
                end_cycle();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
